// File: rtl/uni_shift_pkg.sv
// uni_shift_pkg: shared definitions for the uni_shift_seq slice.
//   - mode_e    : operation encoding presented on the mode port
//   - state_e   : sequencer states
//   - step_ctl_t: boundary-bit description of one single-bit shift
//   - is_shift_mode / step_ctl helpers
// The step description is width-independent: it names the bit entering the
// register, the bit leaving it, and the direction, so any WIDTH can reuse it.
package uni_shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic shift;   // a shift happens in this mode
        logic right;   // 1: towards LSB, 0: towards MSB
        logic fill;    // bit entering at the vacated end
        logic out;     // bit leaving the register
    } step_ctl_t;

    function automatic logic is_shift_mode(mode_e m);
        return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
               (m == MODE_ROL) || (m == MODE_ASR);
    endfunction

    // One-step next value for a mode, expressed through the register's two
    // end bits: lsb = q[0], msb = q[WIDTH-1].
    function automatic step_ctl_t step_ctl(mode_e m, logic lsb, logic msb,
                                           logic ser_in_l, logic ser_in_r);
        step_ctl_t c;
        c = '0;
        case (m)
            MODE_SHR: c = '{shift: 1'b1, right: 1'b1, fill: ser_in_l, out: lsb};
            MODE_SHL: c = '{shift: 1'b1, right: 1'b0, fill: ser_in_r, out: msb};
            MODE_ROR: c = '{shift: 1'b1, right: 1'b1, fill: lsb,      out: lsb};
            MODE_ROL: c = '{shift: 1'b1, right: 1'b0, fill: msb,      out: msb};
            MODE_ASR: c = '{shift: 1'b1, right: 1'b1, fill: msb,      out: lsb};
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uni_shift_step.sv
// uni_shift_step: combinational next-q / next-ser_out datapath.
// Ports:
//   q, ser_cur          current register contents and serial output
//   mode, cnt           operation and remaining/requested shift count
//   ser_in_l, ser_in_r  serial fill bits (MSB side / LSB side)
//   q_next, ser_out_next  value after the step(s)
// Config macro UNI_SHIFT_SEQ_BARREL_EN: when defined, applies cnt shifts at
// once; otherwise applies a single shift whenever cnt is non-zero.
module uni_shift_step
    import uni_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic             ser_cur,
    input  logic [2:0]       mode,
    input  logic [CNTW-1:0]  cnt,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] q_next,
    output logic             ser_out_next
);

    step_ctl_t c;

`ifdef UNI_SHIFT_SEQ_BARREL_EN
    localparam int unsigned MAX_STEPS = (32'd1 << CNTW) - 32'd1;

    // Unrolled chain of the single-step datapath: guarantees the barrel
    // result (including the last bit out, fills past WIDTH and rotate
    // modulo WIDTH) is bit-identical to the one-bit-per-cycle build.
    always_comb begin
        q_next       = q;
        ser_out_next = ser_cur;
        c            = '0;
        for (int unsigned i = 0; i < MAX_STEPS; i++) begin
            if (i < 32'(cnt)) begin
                c = step_ctl(mode_e'(mode), q_next[0], q_next[WIDTH-1],
                             ser_in_l, ser_in_r);
                if (c.shift) begin
                    q_next = c.right ? {c.fill, q_next[WIDTH-1:1]}
                                     : {q_next[WIDTH-2:0], c.fill};
                    ser_out_next = c.out;
                end
            end
        end
    end
`else
    always_comb begin
        q_next       = q;
        ser_out_next = ser_cur;
        c = step_ctl(mode_e'(mode), q[0], q[WIDTH-1], ser_in_l, ser_in_r);
        if (c.shift && (cnt != '0)) begin
            q_next = c.right ? {c.fill, q[WIDTH-1:1]}
                             : {q[WIDTH-2:0], c.fill};
            ser_out_next = c.out;
        end
    end
`endif

endmodule

// File: rtl/uni_shift_seq.sv
// uni_shift_seq: parametrised universal shift register with a shift-by-N
// sequencer (start/busy/done handshake) and registered serial output.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   start, mode, shift_cnt  operation request, sampled only in IDLE
//   load_data           parallel load value
//   ser_in_l, ser_in_r  fill bits for right / left shifts, sampled per shift
//   q                   register contents
//   ser_out             last bit shifted out (holds between shifts)
//   busy                high while the sequencer is running shifts
//   done                one-cycle completion pulse
// Config macro UNI_SHIFT_SEQ_BARREL_EN: when defined, a shift request of any
// count completes in a single RUN cycle.
module uni_shift_seq
    import uni_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNTW-1:0]  shift_cnt,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_e           state, state_next;
    mode_e            mode_r, mode_d, mode_in;
    logic [CNTW-1:0]  remaining, rem_d;
    logic [WIDTH-1:0] q_d, step_q;
    logic             so_d, step_so;

    assign mode_in = mode_e'(mode);
    assign busy    = (state == ST_RUN);
    assign done    = (state == ST_DONE);

    uni_shift_step #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_step (
        .q            (q),
        .ser_cur      (ser_out),
        .mode         (mode_r),
        .cnt          (remaining),
        .ser_in_l     (ser_in_l),
        .ser_in_r     (ser_in_r),
        .q_next       (step_q),
        .ser_out_next (step_so)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            q         <= '0;
            ser_out   <= 1'b0;
            mode_r    <= MODE_HOLD;
            remaining <= '0;
        end else begin
            state     <= state_next;
            q         <= q_d;
            ser_out   <= so_d;
            mode_r    <= mode_d;
            remaining <= rem_d;
        end
    end

    always_comb begin
        state_next = state;
        q_d        = q;
        so_d       = ser_out;
        mode_d     = mode_r;
        rem_d      = remaining;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    // LOAD, HOLD, reserved and zero-count shifts all finish
                    // straight away; only a real shift request enters RUN.
                    state_next = ST_DONE;
                    if (mode_in == MODE_LOAD) begin
                        q_d = load_data;
                    end else if (is_shift_mode(mode_in) && (shift_cnt != '0)) begin
                        mode_d     = mode_in;
                        rem_d      = shift_cnt;
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                q_d  = step_q;
                so_d = step_so;
`ifdef UNI_SHIFT_SEQ_BARREL_EN
                rem_d      = '0;
                state_next = ST_DONE;
`else
                rem_d = remaining - CNTW'(1);
                if (remaining == CNTW'(1)) begin
                    state_next = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
